// File: rtl/trace_check_pkg.sv
// Shared types for the lockstep trace checker: FSM states, mismatch-mask bit
// positions and the per-step trace record {pc, instr, hi, lo}.
package trace_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    localparam int FLD_PC    = 0;
    localparam int FLD_INSTR = 1;
    localparam int FLD_HI    = 2;
    localparam int FLD_LO    = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] hi;
        logic [31:0] lo;
    } trace_rec_t;

endpackage

// File: rtl/trace_field_cmp.sv
// Combinational record comparator: per-field inequality mask plus the golden
// and live values of the highest-priority mismatching field (pc>instr>hi>lo).
// HI/LO only take part when TRACE_CHECK_HILO_EN is defined.
module trace_field_cmp
    import trace_check_pkg::*;
(
    input  trace_rec_t  gold,
    input  trace_rec_t  live,
    output logic [3:0]  mask,
    output logic [31:0] exp_val,
    output logic [31:0] got_val
);

    // Per-field inequality; HI/LO bits stay zero when that compare is disabled
    always_comb begin
        mask            = '0;
        mask[FLD_PC]    = (gold.pc != live.pc);
        mask[FLD_INSTR] = (gold.instr != live.instr);
`ifdef TRACE_CHECK_HILO_EN
        mask[FLD_HI]    = (gold.hi != live.hi);
        mask[FLD_LO]    = (gold.lo != live.lo);
`endif
    end

    // Report the first set mask bit in priority order
    always_comb begin
        exp_val = '0;
        got_val = '0;
        if (mask[FLD_PC]) begin
            exp_val = gold.pc;
            got_val = live.pc;
        end else if (mask[FLD_INSTR]) begin
            exp_val = gold.instr;
            got_val = live.instr;
        end else if (mask[FLD_HI]) begin
            exp_val = gold.hi;
            got_val = live.hi;
        end else if (mask[FLD_LO]) begin
            exp_val = gold.lo;
            got_val = live.lo;
        end
    end

endmodule

// File: rtl/trace_checker.sv
// Lockstep checker: pulls one golden trace record per CPU step, compares it
// one cycle later against the captured live state and latches the first
// divergence. Define TRACE_CHECK_HILO_EN to also compare HI/LO.
module trace_checker
    import trace_check_pkg::*;
#(
    parameter int CYCLES = 3000,
    parameter int IDXW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            cpu_step,
    input  logic [31:0]     cpu_pc,
    input  logic [31:0]     cpu_instr,
    input  logic [31:0]     cpu_hi,
    input  logic [31:0]     cpu_lo,
    input  logic            gold_valid,
    output logic            gold_ready,
    input  logic [31:0]     gold_pc,
    input  logic [31:0]     gold_instr,
    input  logic [31:0]     gold_hi,
    input  logic [31:0]     gold_lo,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic [IDXW-1:0] fail_index,
    output logic [3:0]      fail_field,
    output logic [31:0]     fail_exp,
    output logic [31:0]     fail_got
);

    localparam logic [IDXW-1:0] CYC  = IDXW'(CYCLES);
    localparam logic [IDXW-1:0] LAST = IDXW'(CYCLES - 1);

    state_t          state, next_state;
    logic [IDXW-1:0] issued, compared, cmp_index;
    logic            cmp_valid;
    logic [31:0]     cmp_gold_pc, cmp_gold_instr, cmp_live_pc, cmp_live_instr;
    trace_rec_t      cmp_gold, cmp_live;
    logic [3:0]      cmp_mask;
    logic [31:0]     cmp_exp, cmp_got;
    logic            in_check, mismatch, underrun, restart;

`ifdef TRACE_CHECK_HILO_EN
    logic [31:0]     cmp_gold_hi, cmp_gold_lo, cmp_live_hi, cmp_live_lo;

    assign cmp_gold = '{pc: cmp_gold_pc, instr: cmp_gold_instr, hi: cmp_gold_hi, lo: cmp_gold_lo};
    assign cmp_live = '{pc: cmp_live_pc, instr: cmp_live_instr, hi: cmp_live_hi, lo: cmp_live_lo};
`else
    logic            unused_hilo;

    assign unused_hilo = ^{cpu_hi, cpu_lo, gold_hi, gold_lo};
    assign cmp_gold = '{pc: cmp_gold_pc, instr: cmp_gold_instr, hi: 32'd0, lo: 32'd0};
    assign cmp_live = '{pc: cmp_live_pc, instr: cmp_live_instr, hi: 32'd0, lo: 32'd0};
`endif

    trace_field_cmp u_cmp (
        .gold    (cmp_gold),
        .live    (cmp_live),
        .mask    (cmp_mask),
        .exp_val (cmp_exp),
        .got_val (cmp_got)
    );

    assign in_check = (state == ST_RUN) || (state == ST_DRAIN);
    assign mismatch = in_check && cmp_valid && (|cmp_mask);
    assign underrun = (state == ST_RUN) && cpu_step && !gold_valid;
    assign restart  = start && ((state == ST_IDLE) || (state == ST_PASS) || (state == ST_FAIL));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next state; a compare-stage mismatch wins over every other RUN exit
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_RUN;
            ST_RUN: begin
                if (mismatch)                         next_state = ST_FAIL;
                else if (underrun)                    next_state = ST_FAIL;
                else if (gold_ready && issued == LAST) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (mismatch)                            next_state = ST_FAIL;
                else if (cmp_valid && compared == LAST)  next_state = ST_PASS;
                else                                     next_state = ST_FAIL;
            end
            ST_PASS:  if (start) next_state = ST_RUN;
            ST_FAIL:  if (start) next_state = ST_RUN;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs, combinational from state and inputs
    always_comb begin
        gold_ready = (state == ST_RUN) && cpu_step && gold_valid && (issued < CYC);
        cpu_hold   = (state == ST_RUN) && !gold_valid;
    end

    // Capture stage: register both records on every accepted handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued         <= '0;
            cmp_valid      <= 1'b0;
            cmp_index      <= '0;
            cmp_gold_pc    <= '0;
            cmp_gold_instr <= '0;
            cmp_live_pc    <= '0;
            cmp_live_instr <= '0;
`ifdef TRACE_CHECK_HILO_EN
            cmp_gold_hi    <= '0;
            cmp_gold_lo    <= '0;
            cmp_live_hi    <= '0;
            cmp_live_lo    <= '0;
`endif
        end else if (restart) begin
            issued    <= '0;
            cmp_valid <= 1'b0;
        end else begin
            cmp_valid <= gold_ready;
            if (gold_ready) begin
                cmp_index      <= issued;
                issued         <= issued + 1'b1;
                cmp_gold_pc    <= gold_pc;
                cmp_gold_instr <= gold_instr;
                cmp_live_pc    <= cpu_pc;
                cmp_live_instr <= cpu_instr;
`ifdef TRACE_CHECK_HILO_EN
                cmp_gold_hi    <= gold_hi;
                cmp_gold_lo    <= gold_lo;
                cmp_live_hi    <= cpu_hi;
                cmp_live_lo    <= cpu_lo;
`endif
            end
        end
    end

    // Compare stage and first-failure latch; underrun reports an empty mask
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            compared   <= '0;
            fail_index <= '0;
            fail_field <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else if (restart) begin
            compared   <= '0;
            fail_index <= '0;
            fail_field <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else if (mismatch) begin
            fail_index <= cmp_index;
            fail_field <= cmp_mask;
            fail_exp   <= cmp_exp;
            fail_got   <= cmp_got;
        end else begin
            if (in_check && cmp_valid) compared <= compared + 1'b1;
            if (underrun) begin
                fail_index <= issued;
                fail_field <= '0;
                fail_exp   <= '0;
                fail_got   <= '0;
            end
        end
    end

    // Registered status flags track the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
        end else begin
            busy <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
            done <= (next_state == ST_PASS) || (next_state == ST_FAIL);
            pass <= (next_state == ST_PASS);
            fail <= (next_state == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker with a small run length: a behavioural model of
// the check run is compared against the DUT on every falling edge, and
// directed scenarios add hand-computed literal expectations.
module tb_trace_checker;

    localparam int CYCLES = 12;
    localparam int IDXW   = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            cpu_step = 1'b0;
    logic            gold_valid = 1'b0;
    logic [31:0]     cpu_pc, cpu_instr, cpu_hi, cpu_lo;
    logic [31:0]     gold_pc, gold_instr, gold_hi, gold_lo;
    logic            gold_ready, cpu_hold, busy, done, pass, fail;
    logic [IDXW-1:0] fail_index;
    logic [3:0]      fail_field;
    logic [31:0]     fail_exp, fail_got;

    int              checks = 0;
    int              errors = 0;
    int              rec = 0;
    int              err_idx = -1;
    logic [3:0]      err_kind = 4'b0000;
    bit              checking = 1'b0;

    trace_checker #(.CYCLES(CYCLES), .IDXW(IDXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cpu_step   (cpu_step),
        .cpu_pc     (cpu_pc),
        .cpu_instr  (cpu_instr),
        .cpu_hi     (cpu_hi),
        .cpu_lo     (cpu_lo),
        .gold_valid (gold_valid),
        .gold_ready (gold_ready),
        .gold_pc    (gold_pc),
        .gold_instr (gold_instr),
        .gold_hi    (gold_hi),
        .gold_lo    (gold_lo),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .fail_index (fail_index),
        .fail_field (fail_field),
        .fail_exp   (fail_exp),
        .fail_got   (fail_got)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef enum {MD_IDLE, MD_RUN, MD_DRAIN, MD_DONE} mode_t;
    typedef struct {
        int          due;
        int          idx;
        logic [3:0]  mask;
        logic [31:0] e;
        logic [31:0] g;
    } verdict_t;

    mode_t       m_mode;
    int          m_issued;
    int          m_cycle = 0;
    logic        m_pass, m_fail;
    int          m_fidx;
    logic [3:0]  m_ffield;
    logic [31:0] m_fexp, m_fgot;
    verdict_t    pend[$];
    logic        exp_ready, exp_hold;

    task automatic model_clear();
        m_mode   = MD_IDLE;
        m_issued = 0;
        m_pass   = 1'b0;
        m_fail   = 1'b0;
        m_fidx   = 0;
        m_ffield = 4'd0;
        m_fexp   = 32'd0;
        m_fgot   = 32'd0;
        pend.delete();
    endtask

    task automatic model_fail(input int idx, input logic [3:0] mk, input logic [31:0] e, input logic [31:0] g);
        m_fail   = 1'b1;
        m_pass   = 1'b0;
        m_fidx   = idx;
        m_ffield = mk;
        m_fexp   = e;
        m_fgot   = g;
        m_mode   = MD_DONE;
        pend.delete();
    endtask

    task automatic model_step();
        verdict_t    v;
        bit          hit;
        bit          found;
        int          nfld;
        logic [31:0] gv [4];
        logic [31:0] cv [4];
        m_cycle++;
        if ((m_mode == MD_IDLE || m_mode == MD_DONE) && start) begin
            model_clear();
            m_mode = MD_RUN;
            return;
        end
        if (m_mode == MD_IDLE || m_mode == MD_DONE) return;
        hit = 1'b0;
        if (pend.size() > 0 && pend[0].due == m_cycle) begin
            v = pend.pop_front();
            if (v.mask != 4'd0) begin
                model_fail(v.idx, v.mask, v.e, v.g);
                hit = 1'b1;
            end else if (m_mode == MD_DRAIN) begin
                m_pass = 1'b1;
                m_mode = MD_DONE;
            end
        end
        if (!hit && m_mode == MD_RUN) begin
            if (cpu_step && !gold_valid) begin
                model_fail(m_issued, 4'd0, 32'd0, 32'd0);
            end else if (cpu_step && gold_valid && m_issued < CYCLES) begin
                gv[0] = gold_pc; gv[1] = gold_instr; gv[2] = gold_hi; gv[3] = gold_lo;
                cv[0] = cpu_pc;  cv[1] = cpu_instr;  cv[2] = cpu_hi;  cv[3] = cpu_lo;
`ifdef TRACE_CHECK_HILO_EN
                nfld = 4;
`else
                nfld = 2;
`endif
                v.mask = 4'd0;
                for (int f = 0; f < nfld; f++) v.mask[f] = (gv[f] != cv[f]);
                found = 1'b0;
                v.e = 32'd0;
                v.g = 32'd0;
                for (int f = 0; f < 4; f++) begin
                    if (v.mask[f] && !found) begin
                        found = 1'b1;
                        v.e = gv[f];
                        v.g = cv[f];
                    end
                end
                v.due = m_cycle + 1;
                v.idx = m_issued;
                pend.push_back(v);
                m_issued++;
                if (m_issued == CYCLES) m_mode = MD_DRAIN;
            end
        end
    endtask

    // Model advances on every rising edge, clears on async reset
    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else        model_step();
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                exp_ready = (m_mode == MD_RUN) && cpu_step && gold_valid && (m_issued < CYCLES);
                exp_hold  = (m_mode == MD_RUN) && !gold_valid;
                check_output("cyc.gold_ready", 32'(gold_ready), 32'(exp_ready));
                check_output("cyc.cpu_hold",   32'(cpu_hold),   32'(exp_hold));
                check_output("cyc.busy",       32'(busy),       32'(m_mode == MD_RUN || m_mode == MD_DRAIN));
                check_output("cyc.done",       32'(done),       32'(m_pass || m_fail));
                check_output("cyc.pass",       32'(pass),       32'(m_pass));
                check_output("cyc.fail",       32'(fail),       32'(m_fail));
                check_output("cyc.fail_index", 32'(fail_index), m_fidx);
                check_output("cyc.fail_field", 32'(fail_field), 32'(m_ffield));
                check_output("cyc.fail_exp",   fail_exp,        m_fexp);
                check_output("cyc.fail_got",   fail_got,        m_fgot);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int i, input bit step, input bit valid);
        cpu_step   = step;
        gold_valid = valid;
        gold_pc    = 32'h0040_0000 + 32'(i) * 32'd4;
        gold_instr = 32'h2008_0000 | 32'(i);
        gold_hi    = 32'(i) * 32'd3;
        gold_lo    = ~32'(i);
        cpu_pc     = gold_pc;
        cpu_instr  = gold_instr;
        cpu_hi     = gold_hi;
        cpu_lo     = gold_lo;
        if (i == err_idx) begin
            if (err_kind[0]) cpu_pc = gold_pc + 32'd8;
            if (err_kind[1]) begin
                gold_instr = 32'h0000_0000;
                cpu_instr  = 32'h3c01_0000;
            end
            if (err_kind[3]) cpu_lo = gold_lo ^ 32'd1;
        end
    endtask

    task automatic pulse_start();
        rec = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int k = 0; k < n; k++) begin
            apply_stimulus(rec, 1'b1, 1'b1);
            tick();
            rec++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, ".gold_ready"}, 32'(gold_ready), 32'd0);
        check_output({tag, ".cpu_hold"},   32'(cpu_hold),   32'd0);
        check_output({tag, ".busy"},       32'(busy),       32'd0);
        check_output({tag, ".done"},       32'(done),       32'd0);
        check_output({tag, ".pass"},       32'(pass),       32'd0);
        check_output({tag, ".fail"},       32'(fail),       32'd0);
        check_output({tag, ".fail_index"}, 32'(fail_index), 32'd0);
        check_output({tag, ".fail_field"}, 32'(fail_field), 32'd0);
        check_output({tag, ".fail_exp"},   fail_exp,        32'd0);
        check_output({tag, ".fail_got"},   fail_got,        32'd0);
    endtask

    initial begin
        apply_stimulus(0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        #1 checking = 1'b1;
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check_all_zero("idle");

        // Clean run of all records, with an ignored start mid-run
        pulse_start();
        check_output("run.busy", 32'(busy), 32'd1);
        stream(5);
        start = 1'b1;
        stream(1);
        start = 1'b0;
        stream(6);
        apply_stimulus(rec, 1'b0, 1'b0);
        check_output("drain.busy", 32'(busy), 32'd1);
        check_output("drain.pass", 32'(pass), 32'd0);
        tick();
        check_output("clean.pass", 32'(pass), 32'd1);
        check_output("clean.done", 32'(done), 32'd1);
        check_output("clean.fail", 32'(fail), 32'd0);
        check_output("clean.busy", 32'(busy), 32'd0);

        // Instruction mismatch on record 2
        err_idx  = 2;
        err_kind = 4'b0010;
        pulse_start();
        check_output("restart.pass", 32'(pass), 32'd0);
        check_output("restart.done", 32'(done), 32'd0);
        stream(3);
        check_output("instr.early_fail", 32'(fail), 32'd0);
        stream(1);
        apply_stimulus(rec, 1'b0, 1'b0);
        check_output("instr.fail",  32'(fail),       32'd1);
        check_output("instr.index", 32'(fail_index), 32'd2);
        check_output("instr.field", 32'(fail_field), 32'b0010);
        check_output("instr.exp",   fail_exp,        32'h0000_0000);
        check_output("instr.got",   fail_got,        32'h3c01_0000);
        check_output("instr.pass",  32'(pass),       32'd0);
        repeat (2) tick();
        check_output("instr.hold_fail", 32'(fail), 32'd1);

        // Record 1 with several wrong fields
        err_idx = 1;
`ifdef TRACE_CHECK_HILO_EN
        err_kind = 4'b1001;
`else
        err_kind = 4'b1000;
`endif
        pulse_start();
        check_output("restart2.fail",  32'(fail),       32'd0);
        check_output("restart2.field", 32'(fail_field), 32'd0);
        check_output("restart2.busy",  32'(busy),       32'd1);
        stream(12);
        apply_stimulus(rec, 1'b0, 1'b0);
        tick();
`ifdef TRACE_CHECK_HILO_EN
        check_output("multi.fail",  32'(fail),       32'd1);
        check_output("multi.index", 32'(fail_index), 32'd1);
        check_output("multi.field", 32'(fail_field), 32'b1001);
        check_output("multi.exp",   fail_exp,        32'h0040_0004);
        check_output("multi.got",   fail_got,        32'h0040_000c);
`else
        check_output("lo_only.pass", 32'(pass), 32'd1);
        check_output("lo_only.fail", 32'(fail), 32'd0);
`endif

        // Golden source stall, then an underrun at record 5
        err_idx  = -1;
        err_kind = 4'b0000;
        pulse_start();
        stream(3);
        apply_stimulus(rec, 1'b0, 1'b0);
        #1;
        check_output("stall.cpu_hold",   32'(cpu_hold),   32'd1);
        check_output("stall.gold_ready", 32'(gold_ready), 32'd0);
        repeat (3) tick();
        stream(2);
        check_output("resume.fail", 32'(fail), 32'd0);
        apply_stimulus(rec, 1'b1, 1'b0);
        tick();
        check_output("underrun.fail",  32'(fail),       32'd1);
        check_output("underrun.index", 32'(fail_index), 32'd5);
        check_output("underrun.field", 32'(fail_field), 32'd0);
        check_output("underrun.exp",   fail_exp,        32'd0);
        check_output("underrun.got",   fail_got,        32'd0);
        apply_stimulus(rec, 1'b0, 1'b0);
        tick();

        // Asynchronous reset while record 10 is offered
        pulse_start();
        stream(10);
        apply_stimulus(rec, 1'b1, 1'b1);
        #1 reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        #1 reset = 1'b1;
        apply_stimulus(0, 1'b0, 1'b0);
        tick();
        pulse_start();
        stream(12);
        apply_stimulus(rec, 1'b0, 1'b0);
        tick();
        check_output("after_reset.pass",  32'(pass),       32'd1);
        check_output("after_reset.fail",  32'(fail),       32'd0);
        check_output("after_reset.index", 32'(fail_index), 32'd0);
        check_output("after_reset.done",  32'(done),       32'd1);
        tick();

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
